// File: rtl/instr_fetch.sv
// Multi-cycle y86 fetch: reads a 1/2/9/10-byte instruction from byte-wide sync IMEM and decodes it.
// Optional FETCH_HALT_LOCK_EN: stop accepting PCs after HALT/invalid/error until reset.
module instr_fetch #(
  parameter int IMEM_AW = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [63:0]        pc_i,
  input  logic               pc_valid_i,
  output logic               pc_ready_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic               imem_rd_o,
  input  logic [7:0]         imem_data_i,
  output logic [3:0]         icode_o,
  output logic [3:0]         ifun_o,
  output logic [3:0]         ra_o,
  output logic [3:0]         rb_o,
  output logic [63:0]        valc_o,
  output logic [63:0]        valp_o,
  output logic               instr_valid_o,
  output logic               imem_error_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);
  typedef enum logic [1:0] {IDLE, READ, HOLD} state_e;

  state_e             state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic [3:0]         iss_q, iss_d, rcv_q, rcv_d, len_q, len_d;
  logic               rd_q, rd_d, rdd_q, err_q, err_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [9:0][7:0]    bytes_q, bytes_d;
  logic [3:0]         len_eff;
  logic [63:0]        nxt;
  logic               lock_q;

  function automatic logic [3:0] len_of(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       len_of = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: len_of = 4'd2;
      4'h7, 4'h8:             len_of = 4'd9;
      4'h3, 4'h4, 4'h5:       len_of = 4'd10;
      default:                len_of = 4'd1;
    endcase
  endfunction

  function automatic logic in_range(input logic [63:0] a);
    in_range = (a >> IMEM_AW) == 64'd0;
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    iss_d   = iss_q;
    rcv_d   = rcv_q;
    len_d   = len_q;
    rd_d    = 1'b0;
    err_d   = err_q;
    addr_d  = addr_q;
    bytes_d = bytes_q;
    len_eff = len_q;
    nxt     = pc_q + 64'(iss_q);
    case (state_q)
      IDLE: if (pc_valid_i && pc_ready_o) begin
        pc_d  = pc_i;
        rcv_d = 4'd0;
        len_d = 4'd2;
        err_d = 1'b0;
        if (!in_range(pc_i)) begin
          err_d   = 1'b1;
          state_d = HOLD;
        end else begin
          rd_d    = 1'b1;
          addr_d  = pc_i[IMEM_AW-1:0];
          iss_d   = 4'd1;
          state_d = READ;
        end
      end
      READ: begin
        // byte0 fixes the real length in the same cycle it arrives, so issue never stalls
        if (rdd_q && rcv_q == 4'd0) len_eff = len_of(imem_data_i[7:4]);
        len_d = len_eff;
        if (rdd_q) begin
          if (rcv_q < len_eff) bytes_d[rcv_q] = imem_data_i;
          rcv_d = rcv_q + 4'd1;
        end
        if (rdd_q && (rcv_q + 4'd1) >= len_eff) begin
          state_d = HOLD;
        end else if (iss_q < len_eff) begin
          if (!in_range(nxt)) begin
            err_d   = 1'b1;
            state_d = HOLD;
          end else begin
            rd_d   = 1'b1;
            addr_d = nxt[IMEM_AW-1:0];
            iss_d  = iss_q + 4'd1;
          end
        end
      end
      HOLD: if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      iss_q   <= '0;
      rcv_q   <= '0;
      len_q   <= '0;
      rd_q    <= 1'b0;
      rdd_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      bytes_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      iss_q   <= iss_d;
      rcv_q   <= rcv_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      rdd_q   <= rd_q;
      err_q   <= err_d;
      addr_q  <= addr_d;
      bytes_q <= bytes_d;
    end
  end

  assign imem_rd_o   = rd_q;
  assign imem_addr_o = addr_q;
  assign out_valid_o = state_q == HOLD;
  assign pc_ready_o  = (state_q == IDLE) && !lock_q;

  // fields read as zero outside HOLD; an error presents a NOP at the faulting pc
  always_comb begin
    icode_o       = 4'h0;
    ifun_o        = 4'h0;
    ra_o          = 4'h0;
    rb_o          = 4'h0;
    valc_o        = '0;
    valp_o        = '0;
    instr_valid_o = 1'b0;
    imem_error_o  = 1'b0;
    if (out_valid_o) begin
      if (err_q) begin
        icode_o       = 4'h1;
        ra_o          = 4'hF;
        rb_o          = 4'hF;
        valp_o        = pc_q;
        instr_valid_o = 1'b1;
        imem_error_o  = 1'b1;
      end else begin
        icode_o       = bytes_q[0][7:4];
        ifun_o        = bytes_q[0][3:0];
        ra_o          = 4'hF;
        rb_o          = 4'hF;
        valp_o        = pc_q + 64'(len_q);
        instr_valid_o = bytes_q[0][7:4] <= 4'hB;
        case (bytes_q[0][7:4])
          4'h2, 4'h6, 4'hA, 4'hB: begin
            ra_o = bytes_q[1][7:4];
            rb_o = bytes_q[1][3:0];
          end
          4'h3, 4'h4, 4'h5: begin
            ra_o   = bytes_q[1][7:4];
            rb_o   = bytes_q[1][3:0];
            valc_o = bytes_q[9:2];
          end
          4'h7, 4'h8: valc_o = bytes_q[8:1];
          default: ;
        endcase
      end
    end
  end

`ifdef FETCH_HALT_LOCK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) lock_q <= 1'b0;
    else if (out_valid_o && out_ready_i &&
             (imem_error_o || !instr_valid_o || icode_o == 4'h0)) lock_q <= 1'b1;
  end
`else
  assign lock_q = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: byte-wide sync memory model, read log, hand-computed fields.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst, pc_valid, pc_ready, imem_rd, instr_valid, imem_error, out_valid, out_ready;
  logic [63:0] pc, valc, valp;
  logic [9:0]  imem_addr;
  logic [7:0]  imem_data;
  logic [3:0]  icode, ifun, ra, rb;
  logic [7:0]  mem [0:1023];
  logic [9:0]  rq [$];
  int          total = 0, bad = 0;

`ifdef FETCH_HALT_LOCK_EN
  localparam logic LOCK_RDY = 1'b0;
`else
  localparam logic LOCK_RDY = 1'b1;
`endif

  always #5 clk = ~clk;

  instr_fetch #(.IMEM_AW(10)) dut (
    .clk_i(clk), .rst_i(rst), .pc_i(pc), .pc_valid_i(pc_valid), .pc_ready_o(pc_ready),
    .imem_addr_o(imem_addr), .imem_rd_o(imem_rd), .imem_data_i(imem_data),
    .icode_o(icode), .ifun_o(ifun), .ra_o(ra), .rb_o(rb), .valc_o(valc), .valp_o(valp),
    .instr_valid_o(instr_valid), .imem_error_o(imem_error), .out_valid_o(out_valid),
    .out_ready_i(out_ready)
  );

  always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];
  always @(posedge clk) if (imem_rd) rq.push_back(imem_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ld(input logic [9:0] a, input logic [79:0] v, input int n);
    for (int k = 0; k < n; k++) mem[a + 10'(k)] = v[79 - 8*k -: 8];
  endtask

  task automatic rst_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic fetch(input string tag, input logic [63:0] a, input int lat, input int nrd);
    int n;
    @(negedge clk);
    chk({tag, ".rdy"}, pc_ready, 1);
    rq.delete();
    pc = a;
    pc_valid = 1'b1;
    @(posedge clk);
    #1 pc_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, n, lat);
    chk({tag, ".nrd"}, rq.size(), nrd);
    if (nrd > 0) begin
      chk({tag, ".rd0"}, rq[0], a[9:0]);
      chk({tag, ".rdN"}, rq[nrd-1], a[9:0] + 10'(nrd - 1));
    end
  endtask

  task automatic chkf(input string tag, input logic [3:0] ic, fn, a, b, input logic [63:0] c, p,
                      input logic iv, er);
    chk({tag, ".icode"}, icode, ic);
    chk({tag, ".ifun"}, ifun, fn);
    chk({tag, ".ra"}, ra, a);
    chk({tag, ".rb"}, rb, b);
    chk({tag, ".valc"}, valc, c);
    chk({tag, ".valp"}, valp, p);
    chk({tag, ".iv"}, instr_valid, iv);
    chk({tag, ".err"}, imem_error, er);
  endtask

  task automatic rel(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".ovclr"}, out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; pc_valid = 1'b0; pc = '0; out_ready = 1'b0; imem_data = '0;
    for (int k = 0; k < 1024; k++) mem[k] = 8'h00;
    ld(10'h010, 80'h30F30102030405060708, 10);
    ld(10'h040, 80'h90550000000000000000, 2);
    ld(10'h020, 80'h74887766554433221100, 9);
    ld(10'h080, 80'h20120000000000000000, 2);
    ld(10'h090, 80'hC0000000000000000000, 2);
    ld(10'h0A0, 80'h00000000000000000000, 2);
    ld(10'h3FF, 80'h30000000000000000000, 1);

    rst_dut();
    chk("rst.rdy", pc_ready, 1);
    chk("rst.ov", out_valid, 0);
    chk("rst.rd", imem_rd, 0);
    chkf("rst", 4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0);

    fetch("irmov", 64'h10, 12, 10);
    chkf("irmov", 4'h3, 4'h0, 4'hF, 4'h3, 64'h0807060504030201, 64'h1A, 1'b1, 1'b0);
    rel("irmov");

    fetch("ret", 64'h40, 3, 2);
    chkf("ret", 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41, 1'b1, 1'b0);
    rel("ret");

    fetch("jne", 64'h20, 11, 9);
    chkf("jne", 4'h7, 4'h4, 4'hF, 4'hF, 64'h1122334455667788, 64'h29, 1'b1, 1'b0);
    rel("jne");

    fetch("rrmov", 64'h80, 4, 2);
    chkf("rrmov", 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h82, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      int sz;
      pc = 64'h10;
      pc_valid = 1'b1;
      sz = rq.size();
      @(negedge clk);
      chk("bp.ov", out_valid, 1);
      chk("bp.rdy", pc_ready, 0);
      chk("bp.ra", ra, 4'h1);
      chk("bp.valp", valp, 64'h82);
      chk("bp.nrd", rq.size(), sz);
    end
    pc_valid = 1'b0;
    rel("rrmov");

    // reset in the middle of a long fetch, with reads still in flight
    pc = 64'h10;
    pc_valid = 1'b1;
    @(posedge clk);
    #1 pc_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst.rd", imem_rd, 0);
    chk("mrst.ov", out_valid, 0);
    chk("mrst.rdy", pc_ready, 1);
    chk("mrst.valc", valc, 0);
    repeat (3) @(negedge clk);
    chk("mrst.ov2", out_valid, 0);
    fetch("ret2", 64'h40, 3, 2);
    chkf("ret2", 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41, 1'b1, 1'b0);
    rel("ret2");

    fetch("inv", 64'h90, 3, 2);
    chkf("inv", 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h91, 1'b0, 1'b0);
    rel("inv");
    chk("inv.lock", pc_ready, LOCK_RDY);
    rst_dut();

    fetch("edge", 64'h3FF, 2, 1);
    chkf("edge", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h3FF, 1'b1, 1'b1);
    rel("edge");
    rst_dut();

    fetch("far", 64'h1_0000_0010, 1, 0);
    chkf("far", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1_0000_0010, 1'b1, 1'b1);
    rel("far");
    rst_dut();

    fetch("halt", 64'hA0, 3, 2);
    chkf("halt", 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'hA1, 1'b1, 1'b0);
    rel("halt");
    chk("halt.lock", pc_ready, LOCK_RDY);
    repeat (2) @(negedge clk);
    chk("halt.lock2", pc_ready, LOCK_RDY);
    rst_dut();
    chk("unlock.rdy", pc_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=done");
    $fatal(1);
  end
endmodule
